keccak_parse: RTL and testbench



---
 rtl/keccak_parse_if.sv | 31 +++
 rtl/keccak_parse.sv | 126 ++++++++++++
 tb/tb_keccak_parse.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/keccak_parse_if.sv
// Bundle of the keccak_parse stream ports.
//   start      : one-cycle pulse, begin/restart a polynomial
//   gimme      : one-cycle read request towards keccak
//   kin        : 64-bit squeeze word (byte i = kin[8i+7:8i])
//   kin_valid  : kin valid this cycle
//   coef_out   : accepted 12-bit coefficient
//   coef_valid : coef_out valid
//   coef_ready : downstream accepts
//   coef_idx   : index of presented coefficient
//   done       : level, high after the final handshake
// slave  = keccak_parse side, master = environment side.
interface keccak_parse_if;
  logic        start;
  logic        gimme;
  logic [63:0] kin;
  logic        kin_valid;
  logic [11:0] coef_out;
  logic        coef_valid;
  logic        coef_ready;
  logic [7:0]  coef_idx;
  logic        done;

  modport slave (
    input  start, kin, kin_valid, coef_ready,
    output gimme, coef_out, coef_valid, coef_idx, done
  );
  modport master (
    output start, kin, kin_valid, coef_ready,
    input  gimme, coef_out, coef_valid, coef_idx, done
  );
endinterface

// File: rtl/keccak_parse.sv
// keccak_parse: pulls 64-bit squeeze words from keccak, splits them into a
// little-endian stream of 12-bit candidates and keeps those below Q.
// Accepted coefficients leave on a valid/ready port until N_COEF handshakes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : keccak_parse_if.slave (request/word input, coefficient output)
module keccak_parse #(
  parameter int Q      = 3329,
  parameter int N_COEF = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  keccak_parse_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [87:0] sbuf_q, sbuf_d;     // bit 0 = next stream bit
  logic [6:0]  fill_q, fill_d;
  logic        outst_q, outst_d;   // a gimme is waiting for its word
  logic        cv_q, cv_d;
  logic [11:0] cout_q, cout_d;
  logic [7:0]  cidx_q, cidx_d;
  logic [8:0]  pres_q, pres_d;     // coefficients presented so far
  logic [8:0]  hs_q, hs_d;         // handshakes completed so far

  logic        run, hs, gimme, load, ext;
  logic [11:0] cand;
  logic [87:0] kin_ext;

  always_comb begin
    state_d = state_q;
    sbuf_d  = sbuf_q;
    fill_d  = fill_q;
    outst_d = outst_q;
    cv_d    = cv_q;
    cout_d  = cout_q;
    cidx_d  = cidx_q;
    pres_d  = pres_q;
    hs_d    = hs_q;

    run     = (state_q == S_RUN);
    hs      = cv_q & bus.coef_ready;
    cand    = sbuf_q[11:0];
    kin_ext = {24'd0, bus.kin};
    // Requests stay below 24 buffered bits so a word always fits in 88.
    gimme   = run && (fill_q < 7'd24) && !outst_q && (pres_q < 9'(N_COEF));
    load    = run && outst_q && bus.kin_valid;
    ext     = run && (fill_q >= 7'd12) && (!cv_q || bus.coef_ready)
              && (pres_q < 9'(N_COEF));

    if (ext && load) begin
      // The incoming word lands just above the bits left after the shift.
      sbuf_d = (sbuf_q >> 12) | (kin_ext << (fill_q - 7'd12));
      fill_d = fill_q + 7'd52;
    end else if (load) begin
      sbuf_d = sbuf_q | (kin_ext << fill_q);
      fill_d = fill_q + 7'd64;
    end else if (ext) begin
      sbuf_d = sbuf_q >> 12;
      fill_d = fill_q - 7'd12;
    end

    if (gimme)     outst_d = 1'b1;
    else if (load) outst_d = 1'b0;

    if (hs) begin
      cv_d = 1'b0;
      hs_d = hs_q + 9'd1;
      if (hs_q == 9'(N_COEF - 1)) state_d = S_DONE;
    end

    // A new acceptance refills the slot even while the old one handshakes.
    if (ext && (cand < 12'(Q))) begin
      cv_d   = 1'b1;
      cout_d = cand;
      cidx_d = pres_q[7:0];
      pres_d = pres_q + 9'd1;
    end

    if (bus.start) begin
      state_d = S_RUN;
      sbuf_d  = '0;
      fill_d  = '0;
      outst_d = 1'b0;
      cv_d    = 1'b0;
      cout_d  = '0;
      cidx_d  = '0;
      pres_d  = '0;
      hs_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sbuf_q  <= '0;
      fill_q  <= '0;
      outst_q <= 1'b0;
      cv_q    <= 1'b0;
      cout_q  <= '0;
      cidx_q  <= '0;
      pres_q  <= '0;
      hs_q    <= '0;
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      fill_q  <= fill_d;
      outst_q <= outst_d;
      cv_q    <= cv_d;
      cout_q  <= cout_d;
      cidx_q  <= cidx_d;
      pres_q  <= pres_d;
      hs_q    <= hs_d;
    end
  end

  assign bus.gimme      = gimme;
  assign bus.coef_out   = cout_q;
  assign bus.coef_valid = cv_q;
  assign bus.coef_idx   = cidx_q;
  assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_keccak_parse.sv
module tb_keccak_parse;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keccak_parse_if ifc ();
  keccak_parse #(.Q(3329), .N_COEF(256)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct {
    logic [63:0]      w;
    int               n;
    logic [4:0][11:0] e;
  } vec_t;
  typedef struct {
    logic [11:0] c;
    logic [7:0]  i;
  } exp_t;

  vec_t tbl [5];
  exp_t sb [$];
  int   tests = 0, fails = 0;
  int   gimme_cnt = 0, hs_cnt = 0, cyc = 0, last_hs = -1, nidx = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: observe at negedge, then return just after the next posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && ifc.coef_valid && ifc.coef_ready) begin
      hs_cnt++;
      last_hs = cyc;
      if (sb.size() == 0) chk("unexpected_handshake", {52'd0, ifc.coef_out}, 64'hFFFF);
      else begin
        e = sb.pop_front();
        chk("coef_out", ifc.coef_out, e.c);
        chk("coef_idx", ifc.coef_idx, e.i);
      end
    end
    if (ifc.gimme) gimme_cnt++;
    if (ifc.done) chk("valid_while_done", ifc.coef_valid, 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [11:0] c);
    exp_t e;
    e.c = c;
    e.i = 8'(nidx);
    sb.push_back(e);
    nidx++;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    nidx = 0;
  endtask

  task automatic wait_gimme(input string nm);
    for (int k = 0; k < 10 && !ifc.gimme; k++) step();
    chk(nm, ifc.gimme, 1);
  endtask

  task automatic send_word(input logic [63:0] w);
    step();                // gimme registered as outstanding
    ifc.kin       = w;
    ifc.kin_valid = 1'b1;
    step();
    ifc.kin_valid = 1'b0;
  endtask

  logic [11:0] hold_c;
  logic [7:0]  hold_i;
  int          g0;
  logic        pend;

  initial begin
    tbl[0] = '{64'h0123456789ABCDEF, 4, {12'd0, 12'd291, 12'd1110, 12'd1929, 12'd2748}};
    tbl[1] = '{64'h0000000000D00D01, 4, {12'd0, 12'd0, 12'd0, 12'd0, 12'd3328}};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 0, {12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
    tbl[3] = '{64'h0000000000000D00, 5, {12'd0, 12'd0, 12'd0, 12'd0, 12'd3328}};
    tbl[4] = '{64'h05DC000FFFCFF001, 4, {12'd0, 12'd1500, 12'd0, 12'd3327, 12'd1}};

    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.kin = '0; ifc.kin_valid = 1'b0; ifc.coef_ready = 1'b1;

    // Reset with random inputs
    for (int k = 0; k < 8; k++) begin
      ifc.start = 1'($urandom); ifc.kin_valid = 1'($urandom);
      ifc.kin = {$urandom, $urandom}; ifc.coef_ready = 1'($urandom);
      step();
      chk("reset_outputs", {ifc.gimme, ifc.coef_valid, ifc.coef_out, ifc.coef_idx, ifc.done}, 0);
    end
    ifc.start = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ifc.kin_valid = 1'($urandom);
      step();
      chk("no_gimme_before_start", ifc.gimme, 0);
    end
    ifc.kin_valid = 1'b0;
    ifc.coef_ready = 1'b1;

    // Table: one word per run, ready held high
    for (int t = 0; t < 5; t++) begin
      gimme_cnt = 0;
      pulse_start();
      wait_gimme("first_gimme");
      for (int j = 0; j < tbl[t].n; j++) push(tbl[t].e[j]);
      send_word(tbl[t].w);
      repeat (14) step();
      chk("sb_drained", sb.size(), 0);
      chk("gimme_count", gimme_cnt, 2);
    end

    // Abort while a request is outstanding; the stale word must be ignored
    gimme_cnt = 0;
    pulse_start();
    chk("abort_gimme", ifc.gimme, 1);
    ifc.kin = 64'h0123456789ABCDEF;
    ifc.kin_valid = 1'b1;
    step();
    ifc.kin_valid = 1'b0;
    ifc.kin = 64'h0000000000D00D01;
    ifc.kin_valid = 1'b1;
    push(12'd3328); push(12'd0); push(12'd0); push(12'd0);
    step();
    ifc.kin_valid = 1'b0;
    repeat (14) step();
    chk("abort_drained", sb.size(), 0);
    chk("abort_gimme_count", gimme_cnt, 2);

    // Backpressure
    ifc.coef_ready = 1'b0;
    pulse_start();
    wait_gimme("bp_gimme");
    push(12'd2748); push(12'd1929); push(12'd1110); push(12'd291);
    send_word(64'h0123456789ABCDEF);
    for (int k = 0; k < 10 && !ifc.coef_valid; k++) step();
    chk("bp_valid", ifc.coef_valid, 1);
    hold_c = ifc.coef_out;
    hold_i = ifc.coef_idx;
    g0 = gimme_cnt;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", ifc.coef_valid, 1);
      chk("bp_hold_out", ifc.coef_out, hold_c);
      chk("bp_hold_idx", ifc.coef_idx, hold_i);
    end
    chk("bp_extra_gimme_le1", (gimme_cnt - g0) <= 1, 1);
    ifc.coef_ready = 1'b1;
    repeat (14) step();
    chk("bp_drained", sb.size(), 0);

    // Full run of zero words with an auto-responding upstream
    gimme_cnt = 0;
    hs_cnt = 0;
    pulse_start();
    for (int i = 0; i < 256; i++) push(12'd0);
    pend = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (ifc.done) break;
      ifc.kin = '0;
      ifc.kin_valid = pend;
      pend = ifc.gimme;
      step();
    end
    ifc.kin_valid = 1'b0;
    chk("full_done", ifc.done, 1);
    chk("full_done_timing", cyc, last_hs + 1);
    chk("full_handshakes", hs_cnt, 256);
    chk("full_drained", sb.size(), 0);
    chk("full_gimme_le49", gimme_cnt <= 49, 1);
    chk("full_idx_last", ifc.coef_idx, 255);

    // Late word after DONE is ignored
    ifc.kin = 64'h0123456789ABCDEF;
    ifc.kin_valid = 1'b1;
    step();
    ifc.kin_valid = 1'b0;
    repeat (5) step();
    chk("late_done_held", ifc.done, 1);
    chk("late_idx_held", ifc.coef_idx, 255);

    pulse_start();
    chk("restart_idx", ifc.coef_idx, 0);
    chk("restart_done", ifc.done, 0);

    // Reset mid-run
    rst_n = 1'b0;
    step();
    chk("midrun_reset", {ifc.gimme, ifc.coef_valid, ifc.coef_out, ifc.coef_idx, ifc.done}, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
